// File: rtl/game_pkg.sv
// Shared types and helpers for the game phase sequencer: sequencer states,
// pixel width and the RGB444 saturating compositor.
package game_pkg;

    localparam int PIXEL_W = 12;

    typedef enum logic [2:0] {
        ST_ROUND_RST,
        ST_START,
        ST_RUN,
        ST_GAMEOVER,
        ST_VICTORY
    } seq_state_t;

    // Each 4-bit channel adds independently and clamps at full intensity.
    function automatic logic [PIXEL_W-1:0] sat_add_rgb444(
        input logic [PIXEL_W-1:0] a,
        input logic [PIXEL_W-1:0] b
    );
        logic [4:0]         sum;
        logic [PIXEL_W-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, a[c*4 +: 4]} + {1'b0, b[c*4 +: 4]};
            res[c*4 +: 4] = sum[4] ? 4'hF : sum[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/hp_tracker.sv
// Player HP register: nets damage and heal in one cycle, clamps to [0, HP_MAX]
// and flags when the value about to be stored is zero.
module hp_tracker
#(
    parameter int HP_MAX = 20,
    parameter int HP_W   = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            restart,
    input  logic            damage_valid,
    input  logic [HP_W-1:0] damage_amt,
    input  logic            heal_valid,
    input  logic [HP_W-1:0] heal_amt,
    output logic [HP_W-1:0] hp,
    output logic            hp_zero
);

    localparam int EXT_W = HP_W + 2;

    logic [HP_W-1:0]         r_hp;
    logic [HP_W-1:0]         w_hp_next;
    logic signed [EXT_W-1:0] w_sum;

    // Two extra bits hold both the negative underflow and the heal overshoot.
    always_comb begin
        w_sum = $signed({2'b00, r_hp});
        if (damage_valid) begin
            w_sum = w_sum - $signed({2'b00, damage_amt});
        end
        if (heal_valid) begin
            w_sum = w_sum + $signed({2'b00, heal_amt});
        end
        w_hp_next = r_hp;
        if (enable) begin
            if (w_sum[EXT_W-1]) begin
                w_hp_next = '0;
            end else if (w_sum[EXT_W-2:0] > (EXT_W-1)'(HP_MAX)) begin
                w_hp_next = HP_W'(HP_MAX);
            end else begin
                w_hp_next = w_sum[HP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_hp <= HP_W'(HP_MAX);
        end else if (enable) begin
            r_hp <= w_hp_next;
        end
    end

    assign hp      = r_hp;
    assign hp_zero = (w_hp_next == '0);

endmodule

// File: rtl/game_phase_sequencer.sv
// Round-robin turn/phase controller with HP tracking and pixel compositing.
// Optional build macro PHASE_TIMEOUT_EN adds a per-phase timeout and timeout_out.
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int HP_MAX         = 20,
    parameter int HP_W           = 8,
    parameter int TIMEOUT_CYCLES = 600000,
    localparam int IDX_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         phase_finish_in,
    input  logic [NUM_PHASES*PIXEL_W-1:0] phase_pixel_in,
    input  logic [PIXEL_W-1:0]            overlay_pixel_in,
    input  logic                          damage_valid_in,
    input  logic [HP_W-1:0]               damage_amt_in,
    input  logic                          heal_valid_in,
    input  logic [HP_W-1:0]               heal_amt_in,
    input  logic                          enemy_defeated_in,
    input  logic                          restart_in,
    output logic [IDX_W-1:0]              phase_idx_out,
    output logic                          phase_start_out,
    output logic                          phase_rst_out,
    output logic [HP_W-1:0]               hp_out,
    output logic [15:0]                   round_out,
    output logic                          game_over_out,
    output logic                          victory_out,
`ifdef PHASE_TIMEOUT_EN
    output logic                          timeout_out,
`endif
    output logic [PIXEL_W-1:0]            pixel_out
);

    seq_state_t            r_state, w_state_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [15:0]           r_round, w_round_next;
    logic [NUM_PHASES-1:0] r_finish_prev;
    logic [NUM_PHASES-1:0] w_edge;
    logic [NUM_PHASES-1:0] w_sel;
    logic [PIXEL_W-1:0]    w_phase_pix [NUM_PHASES];
    logic [PIXEL_W-1:0]    w_sel_pix;
    logic [PIXEL_W-1:0]    w_base_pix;
    logic                  w_active_edge;
    logic                  w_last_phase;
    logic                  w_hp_zero;
    logic                  w_hp_enable;
    logic                  w_restart;
    logic                  w_timeout_hit;

    assign w_edge = phase_finish_in & ~r_finish_prev;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
            assign w_sel[gi]       = (r_idx == IDX_W'(gi));
            assign w_phase_pix[gi] = phase_pixel_in[gi*PIXEL_W +: PIXEL_W];
        end
    endgenerate

    assign w_active_edge = |(w_edge & w_sel);
    assign w_last_phase  = (r_idx == IDX_W'(NUM_PHASES-1));

    always_comb begin
        w_sel_pix = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (w_sel[i]) begin
                w_sel_pix = w_phase_pix[i];
            end
        end
    end

`ifdef PHASE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;
    logic             w_timeout_fire;

    assign w_timeout_hit  = (r_state == ST_RUN) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1));
    // A real finish edge or a higher-priority event suppresses the timeout pulse.
    assign w_timeout_fire = w_timeout_hit && !w_active_edge && !w_hp_zero && !enemy_defeated_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_fire;
            if (r_state == ST_START) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign timeout_out = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_round_next = r_round;
        w_restart    = 1'b0;
        case (r_state)
            ST_ROUND_RST: begin
                w_idx_next   = '0;
                w_state_next = ST_START;
            end
            ST_START: begin
                w_state_next = w_hp_zero ? ST_GAMEOVER : ST_RUN;
            end
            ST_RUN: begin
                if (w_hp_zero) begin
                    w_state_next = ST_GAMEOVER;
                end else if (enemy_defeated_in) begin
                    w_state_next = ST_VICTORY;
                end else if (w_active_edge || w_timeout_hit) begin
                    if (w_last_phase) begin
                        w_round_next = r_round + 16'd1;
                        w_idx_next   = '0;
                        w_state_next = ST_ROUND_RST;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_state_next = ST_START;
                    end
                end
            end
            ST_GAMEOVER, ST_VICTORY: begin
                if (restart_in) begin
                    w_restart    = 1'b1;
                    w_round_next = '0;
                    w_idx_next   = '0;
                    w_state_next = ST_ROUND_RST;
                end
            end
            default: begin
                w_idx_next   = '0;
                w_state_next = ST_ROUND_RST;
            end
        endcase
    end

    // Sampling finish levels every cycle means a level already high in START
    // is not seen as an edge once RUN begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ROUND_RST;
            r_idx         <= '0;
            r_round       <= '0;
            r_finish_prev <= '0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_round       <= w_round_next;
            r_finish_prev <= phase_finish_in;
        end
    end

    assign w_hp_enable = (r_state == ST_RUN) || (r_state == ST_START);

    hp_tracker #(
        .HP_MAX (HP_MAX),
        .HP_W   (HP_W)
    ) u_hp_tracker (
        .clk          (clk),
        .rst          (rst),
        .enable       (w_hp_enable),
        .restart      (w_restart),
        .damage_valid (damage_valid_in),
        .damage_amt   (damage_amt_in),
        .heal_valid   (heal_valid_in),
        .heal_amt     (heal_amt_in),
        .hp           (hp_out),
        .hp_zero      (w_hp_zero)
    );

    always_comb begin
        w_base_pix = w_sel_pix;
        if (r_state == ST_GAMEOVER) begin
            w_base_pix = '0;
        end else if (r_state == ST_VICTORY) begin
            w_base_pix = w_phase_pix[0];
        end
    end

    assign pixel_out       = sat_add_rgb444(w_base_pix, overlay_pixel_in);
    assign phase_idx_out   = r_idx;
    assign round_out       = r_round;
    assign phase_rst_out   = (r_state == ST_ROUND_RST) && !rst;
    assign phase_start_out = (r_state == ST_START) && !rst;
    assign game_over_out   = (r_state == ST_GAMEOVER);
    assign victory_out     = (r_state == ST_VICTORY);

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed bench for game_phase_sequencer: a flag-based reference model is
// checked against the DUT every cycle, plus literal spot checks.
module tb_game_phase_sequencer;

    localparam int NP     = 3;
    localparam int HP_MAX = 20;
    localparam int HP_W   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   phase_finish_in;
    logic [NP*12-1:0] phase_pixel_in;
    logic [11:0]     overlay_pixel_in;
    logic            damage_valid_in;
    logic [HP_W-1:0] damage_amt_in;
    logic            heal_valid_in;
    logic [HP_W-1:0] heal_amt_in;
    logic            enemy_defeated_in;
    logic            restart_in;
    logic [1:0]      phase_idx_out;
    logic            phase_start_out;
    logic            phase_rst_out;
    logic [HP_W-1:0] hp_out;
    logic [15:0]     round_out;
    logic            game_over_out;
    logic            victory_out;
    logic [11:0]     pixel_out;
`ifdef PHASE_TIMEOUT_EN
    logic            timeout_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_end 0 = playing, 1 = game over, 2 = victory.
    int      m_idx, m_hp, m_round, m_end;
    bit      m_rstp, m_startp;
    logic [NP-1:0] m_prev;

    always #5 clk = ~clk;

    game_phase_sequencer #(
        .NUM_PHASES (NP),
        .HP_MAX     (HP_MAX),
        .HP_W       (HP_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .phase_finish_in   (phase_finish_in),
        .phase_pixel_in    (phase_pixel_in),
        .overlay_pixel_in  (overlay_pixel_in),
        .damage_valid_in   (damage_valid_in),
        .damage_amt_in     (damage_amt_in),
        .heal_valid_in     (heal_valid_in),
        .heal_amt_in       (heal_amt_in),
        .enemy_defeated_in (enemy_defeated_in),
        .restart_in        (restart_in),
        .phase_idx_out     (phase_idx_out),
        .phase_start_out   (phase_start_out),
        .phase_rst_out     (phase_rst_out),
        .hp_out            (hp_out),
        .round_out         (round_out),
        .game_over_out     (game_over_out),
        .victory_out       (victory_out),
`ifdef PHASE_TIMEOUT_EN
        .timeout_out       (timeout_out),
`endif
        .pixel_out         (pixel_out)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int sat_pix(input int a, input int b);
        int r = 0;
        for (int c = 0; c < 3; c++) begin
            int s = ((a >> (4*c)) & 15) + ((b >> (4*c)) & 15);
            if (s > 15) s = 15;
            r = r | (s << (4*c));
        end
        return r;
    endfunction

    task automatic model_step();
        int  nhp;
        bit  was_start;
        bit  edge_hit;
        if (rst) begin
            m_idx = 0; m_hp = HP_MAX; m_round = 0; m_end = 0;
            m_rstp = 1'b1; m_startp = 1'b0; m_prev = '0;
        end else begin
            if (m_end != 0) begin
                if (restart_in) begin
                    m_hp = HP_MAX; m_round = 0; m_end = 0; m_rstp = 1'b1; m_idx = 0;
                end
            end else if (m_rstp) begin
                m_rstp = 1'b0; m_startp = 1'b1; m_idx = 0;
            end else begin
                was_start = m_startp;
                edge_hit  = phase_finish_in[m_idx] && !m_prev[m_idx];
                nhp = m_hp - (damage_valid_in ? int'(damage_amt_in) : 0)
                           + (heal_valid_in ? int'(heal_amt_in) : 0);
                if (nhp < 0) nhp = 0;
                if (nhp > HP_MAX) nhp = HP_MAX;
                m_hp = nhp;
                m_startp = 1'b0;
                if (nhp == 0) begin
                    m_end = 1;
                end else if (!was_start && enemy_defeated_in) begin
                    m_end = 2;
                end else if (!was_start && edge_hit) begin
                    if (m_idx == NP-1) begin
                        m_round = (m_round + 1) % 65536;
                        m_idx = 0;
                        m_rstp = 1'b1;
                    end else begin
                        m_idx = m_idx + 1;
                        m_startp = 1'b1;
                    end
                end
            end
            m_prev = phase_finish_in;
        end
    endtask

    task automatic compare_all();
        int base;
        if (m_end == 1)      base = 0;
        else if (m_end == 2) base = int'(phase_pixel_in[11:0]);
        else                 base = int'((phase_pixel_in >> (12*m_idx)) & 36'hFFF);
        chk("idx",     int'(phase_idx_out),   m_idx);
        chk("start",   int'(phase_start_out), int'(m_startp && !rst));
        chk("rstp",    int'(phase_rst_out),   int'(m_rstp && !rst));
        chk("hp",      int'(hp_out),          m_hp);
        chk("round",   int'(round_out),       m_round);
        chk("gameover",int'(game_over_out),   int'(m_end == 1));
        chk("victory", int'(victory_out),     int'(m_end == 2));
        chk("pixel",   int'(pixel_out),       sat_pix(base, int'(overlay_pixel_in)));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_finish(input int k);
        phase_finish_in[k] = 1'b1;
        tick(1);
        phase_finish_in[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        phase_finish_in   = '0;
        phase_pixel_in    = {12'h4C7, 12'hF80, 12'h123};
        overlay_pixel_in  = 12'h1A5;
        damage_valid_in   = 1'b0;
        damage_amt_in     = '0;
        heal_valid_in     = 1'b0;
        heal_amt_in       = '0;
        enemy_defeated_in = 1'b0;
        restart_in        = 1'b0;
        tick(3);
        rst = 1'b0;
        #1;
        chk("lit_rst_pulse", int'(phase_rst_out), 1);
        chk("lit_rst_hp",    int'(hp_out), 20);
        chk("lit_rst_round", int'(round_out), 0);
        tick(1);
        chk("lit_start0", int'(phase_start_out), 1);
        tick(1);

        // One full round of in-order finish edges.
        pulse_finish(0);
        chk("lit_start1_idx", int'(phase_idx_out), 1);
        tick(1);
        pulse_finish(1);
        chk("lit_start2_idx", int'(phase_idx_out), 2);
        tick(1);
        pulse_finish(2);
        chk("lit_round_rst", int'(phase_rst_out), 1);
        chk("lit_round1",    int'(round_out), 1);
        chk("lit_round_idx", int'(phase_idx_out), 0);
        tick(2);

        // Finish[1] held high across START; non-active edge ignored.
        phase_finish_in[0] = 1'b1;
        phase_finish_in[1] = 1'b1;
        tick(1);
        phase_finish_in[0] = 1'b0;
        tick(1);
        pulse_finish(2);
        chk("lit_ignore_idx", int'(phase_idx_out), 1);
        tick(3);
        chk("lit_hold_idx", int'(phase_idx_out), 1);
        chk("lit_pix_ff5",  int'(pixel_out), 12'hFF5);
        phase_finish_in[1] = 1'b0;
        tick(1);
        phase_finish_in[1] = 1'b1;
        tick(1);
        chk("lit_reedge_idx", int'(phase_idx_out), 2);
        phase_finish_in[1] = 1'b0;
        tick(1);

        // HP arithmetic and game over priority.
        damage_valid_in = 1'b1; damage_amt_in = 8'd5;
        heal_valid_in = 1'b1;   heal_amt_in = 8'd3;
        tick(1);
        damage_valid_in = 1'b0; heal_valid_in = 1'b0;
        chk("lit_hp18", int'(hp_out), 18);
        heal_valid_in = 1'b1; heal_amt_in = 8'd10;
        tick(1);
        heal_valid_in = 1'b0;
        chk("lit_hp_clamp20", int'(hp_out), 20);
        damage_valid_in = 1'b1; damage_amt_in = 8'd20; enemy_defeated_in = 1'b1;
        tick(1);
        damage_valid_in = 1'b0; enemy_defeated_in = 1'b0;
        chk("lit_go",     int'(game_over_out), 1);
        chk("lit_go_vic", int'(victory_out), 0);
        chk("lit_go_pix", int'(pixel_out), 12'h1A5);
        damage_valid_in = 1'b1; damage_amt_in = 8'd3;
        phase_finish_in[2] = 1'b1;
        tick(2);
        damage_valid_in = 1'b0; phase_finish_in[2] = 1'b0;
        chk("lit_go_hold_hp",    int'(hp_out), 0);
        chk("lit_go_hold_round", int'(round_out), 1);
        restart_in = 1'b1;
        tick(1);
        restart_in = 1'b0;
        chk("lit_restart_hp",    int'(hp_out), 20);
        chk("lit_restart_round", int'(round_out), 0);
        chk("lit_restart_rstp",  int'(phase_rst_out), 1);
        tick(2);

        // Overkill damage clamps at zero.
        damage_valid_in = 1'b1; damage_amt_in = 8'd25;
        tick(1);
        damage_valid_in = 1'b0;
        chk("lit_overkill_hp", int'(hp_out), 0);
        chk("lit_overkill_go", int'(game_over_out), 1);
        restart_in = 1'b1;
        tick(1);
        restart_in = 1'b0;
        tick(2);

        // Victory from phase 1 shows phase 0 pixel.
        pulse_finish(0);
        tick(1);
        restart_in = 1'b1;
        tick(1);
        restart_in = 1'b0;
        chk("lit_restart_ignored", int'(phase_idx_out), 1);
        enemy_defeated_in = 1'b1;
        tick(1);
        enemy_defeated_in = 1'b0;
        chk("lit_victory",     int'(victory_out), 1);
        chk("lit_victory_pix", int'(pixel_out), 12'h2C8);
        restart_in = 1'b1;
        tick(1);
        restart_in = 1'b0;
        tick(2);
        overlay_pixel_in = 12'h000;
        #1;
        chk("lit_pix_123", int'(pixel_out), 12'h123);
        tick(1);

        // Reset in the middle of a round.
        pulse_finish(0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("lit_midrst_idx",  int'(phase_idx_out), 0);
        chk("lit_midrst_rstp", int'(phase_rst_out), 0);
        rst = 1'b0;
        #1;
        chk("lit_midrst_pulse", int'(phase_rst_out), 1);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
